// File: rtl/door_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : door_access_controller
// Description : Door strike / failed-attempt lockout sequencer fed by the
//               password datapath verdict; optional lockout alarm blink is
//               enabled by defining ALARM_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module door_access_controller #(
  parameter int unsigned UNLOCK_TICKS  = 250,
  parameter int unsigned LOCKOUT_TICKS = 1500,
  parameter int unsigned MAX_FAILS     = 3,
  parameter int unsigned CNT_W         = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       enter,
  input  logic       green_LED,
  input  logic       red_LED,
  output logic       unlock,
  output logic       alarm,
  output logic       locked_out,
  output logic       clear_entry,
  output logic [3:0] fail_count
);

  localparam logic [CNT_W-1:0] UNLOCK_LOAD  = CNT_W'(UNLOCK_TICKS);
  localparam logic [CNT_W-1:0] LOCKOUT_LOAD = CNT_W'(LOCKOUT_TICKS);
  localparam logic [CNT_W-1:0] TIMER_ONE    = CNT_W'(1);
  localparam logic [3:0]       MAX_FC       = 4'(MAX_FAILS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       fail_count_q, fail_count_d;
  logic             enter_q;
  logic             unlock_q, unlock_d;
  logic             alarm_q, alarm_d;
  logic             locked_out_q, locked_out_d;
  logic             clear_entry_q, clear_entry_d;
  logic             rise;
  logic [3:0]       fail_inc;

  assign rise     = enter & ~enter_q;
  // Saturating increment: the count can never wrap past the lockout threshold.
  assign fail_inc = (fail_count_q < MAX_FC) ? fail_count_q + 4'd1 : fail_count_q;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    fail_count_d  = fail_count_q;
    unlock_d      = unlock_q;
    alarm_d       = alarm_q;
    locked_out_d  = locked_out_q;
    clear_entry_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = EVAL;
        end
      end

      EVAL: begin
        clear_entry_d = 1'b1;
        if (green_LED && !red_LED) begin
          fail_count_d = 4'd0;
          timer_d      = UNLOCK_LOAD;
          unlock_d     = 1'b1;
          state_d      = OPEN;
        end else begin
          fail_count_d = fail_inc;
          if (fail_inc == MAX_FC) begin
            timer_d      = LOCKOUT_LOAD;
            alarm_d      = 1'b1;
            locked_out_d = 1'b1;
            state_d      = LOCKOUT;
          end else begin
            state_d = IDLE;
          end
        end
      end

      OPEN: begin
        if (tick) begin
          if (timer_q <= TIMER_ONE) begin
            timer_d  = '0;
            unlock_d = 1'b0;
            state_d  = IDLE;
          end else begin
            timer_d = timer_q - TIMER_ONE;
          end
        end
      end

      LOCKOUT: begin
        if (tick) begin
          if (timer_q <= TIMER_ONE) begin
            timer_d      = '0;
            fail_count_d = 4'd0;
            alarm_d      = 1'b0;
            locked_out_d = 1'b0;
            state_d      = IDLE;
          end else begin
            timer_d = timer_q - TIMER_ONE;
`ifdef ALARM_BLINK_EN
            alarm_d = ~alarm_q;
`else
            alarm_d = 1'b1;
`endif
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      fail_count_q  <= 4'd0;
      enter_q       <= 1'b0;
      unlock_q      <= 1'b0;
      alarm_q       <= 1'b0;
      locked_out_q  <= 1'b0;
      clear_entry_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      fail_count_q  <= fail_count_d;
      enter_q       <= enter;
      unlock_q      <= unlock_d;
      alarm_q       <= alarm_d;
      locked_out_q  <= locked_out_d;
      clear_entry_q <= clear_entry_d;
    end
  end

  assign unlock      = unlock_q;
  assign alarm       = alarm_q;
  assign locked_out  = locked_out_q;
  assign clear_entry = clear_entry_q;
  assign fail_count  = fail_count_q;

endmodule
`default_nettype wire

// File: tb/tb_door_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_door_access_controller
// Description : Directed vector bench for door_access_controller
//               (UNLOCK_TICKS=4, LOCKOUT_TICKS=6, MAX_FAILS=3, tick every 5 clk).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_door_access_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       enter;
  logic       green_LED;
  logic       red_LED;
  logic       unlock;
  logic       alarm;
  logic       locked_out;
  logic       clear_entry;
  logic [3:0] fail_count;

  int checks   = 0;
  int failures = 0;

  door_access_controller #(
    .UNLOCK_TICKS (4),
    .LOCKOUT_TICKS(6),
    .MAX_FAILS    (3),
    .CNT_W        (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .enter      (enter),
    .green_LED  (green_LED),
    .red_LED    (red_LED),
    .unlock     (unlock),
    .alarm      (alarm),
    .locked_out (locked_out),
    .clear_entry(clear_entry),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  // One record = inputs held for 'rep' cycles, outputs checked after each edge.
  // 'blk' is the expected alarm when the blink option is compiled in.
  typedef struct {
    int         rep;
    logic       en, gr, rd, tk;
    logic       unl, alm, blk, lk, clr;
    logic [3:0] fc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int rep, logic en, logic gr, logic rd, logic tk,
                              logic unl, logic alm, logic blk, logic lk, logic clr,
                              logic [3:0] fc);
    vec_t v;
    v.rep = rep; v.en = en; v.gr = gr; v.rd = rd; v.tk = tk;
    v.unl = unl; v.alm = alm; v.blk = blk; v.lk = lk; v.clr = clr; v.fc = fc;
    return v;
  endfunction

  function automatic logic [7:0] pack(logic unl, logic alm, logic lk, logic clr, logic [3:0] fc);
    return {unl, alm, lk, clr, fc};
  endfunction

  task automatic chk(string name, logic [7:0] exp);
    logic [7:0] got;
    got = {unlock, alarm, locked_out, clear_entry, fail_count};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got{unl,alm,lk,clr,fc}=%b exp=%b", name, got, exp);
    end
  endtask

  // Called at a negedge: drive, let one posedge pass, return at the next negedge.
  task automatic apply(logic en, logic gr, logic rd, logic tk);
    enter = en; green_LED = gr; red_LED = rd; tick = tk;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic exp_alm;

  initial begin
    reset = 1'b0; enter = 1'b1; green_LED = 1'b1; red_LED = 1'b0; tick = 1'b0;

    // Success / ignore-in-OPEN
    vecs.push_back(mk(1, 1,1,0,0, 0,0,0,0,0, 4'd0));
    vecs.push_back(mk(1, 1,1,0,1, 1,0,0,0,1, 4'd0));
    vecs.push_back(mk(1, 0,0,0,0, 1,0,0,0,0, 4'd0));
    vecs.push_back(mk(3, 1,0,0,0, 1,0,0,0,0, 4'd0));
    vecs.push_back(mk(1, 0,0,0,1, 1,0,0,0,0, 4'd0));
    vecs.push_back(mk(4, 0,0,0,0, 1,0,0,0,0, 4'd0));
    vecs.push_back(mk(1, 0,0,0,1, 1,0,0,0,0, 4'd0));
    vecs.push_back(mk(4, 0,0,0,0, 1,0,0,0,0, 4'd0));
    vecs.push_back(mk(1, 0,0,0,1, 1,0,0,0,0, 4'd0));
    vecs.push_back(mk(4, 0,0,0,0, 1,0,0,0,0, 4'd0));
    vecs.push_back(mk(1, 0,0,0,1, 0,0,0,0,0, 4'd0));
    vecs.push_back(mk(3, 0,0,0,0, 0,0,0,0,0, 4'd0));
    // Failures: red, red, both -> lockout; rises ignored; enter held across exit
    vecs.push_back(mk(1, 1,0,1,0, 0,0,0,0,0, 4'd0));
    vecs.push_back(mk(1, 1,0,1,0, 0,0,0,0,1, 4'd1));
    vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,0, 4'd1));
    vecs.push_back(mk(1, 1,0,1,0, 0,0,0,0,0, 4'd1));
    vecs.push_back(mk(1, 1,0,1,0, 0,0,0,0,1, 4'd2));
    vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,0, 4'd2));
    vecs.push_back(mk(1, 1,1,1,0, 0,0,0,0,0, 4'd2));
    vecs.push_back(mk(1, 1,1,1,0, 0,1,1,1,1, 4'd3));
    vecs.push_back(mk(1, 0,0,0,0, 0,1,1,1,0, 4'd3));
    vecs.push_back(mk(2, 1,1,0,0, 0,1,1,1,0, 4'd3));
    vecs.push_back(mk(1, 1,1,0,1, 0,1,0,1,0, 4'd3));
    vecs.push_back(mk(4, 1,1,0,0, 0,1,0,1,0, 4'd3));
    vecs.push_back(mk(1, 1,1,0,1, 0,1,1,1,0, 4'd3));
    vecs.push_back(mk(4, 1,1,0,0, 0,1,1,1,0, 4'd3));
    vecs.push_back(mk(1, 1,1,0,1, 0,1,0,1,0, 4'd3));
    vecs.push_back(mk(4, 1,1,0,0, 0,1,0,1,0, 4'd3));
    vecs.push_back(mk(1, 1,1,0,1, 0,1,1,1,0, 4'd3));
    vecs.push_back(mk(4, 1,1,0,0, 0,1,1,1,0, 4'd3));
    vecs.push_back(mk(1, 1,1,0,1, 0,1,0,1,0, 4'd3));
    vecs.push_back(mk(4, 1,1,0,0, 0,1,0,1,0, 4'd3));
    vecs.push_back(mk(1, 1,1,0,1, 0,0,0,0,0, 4'd0));
    vecs.push_back(mk(3, 1,1,0,0, 0,0,0,0,0, 4'd0));
    // Neither-verdict failure, then success clears the count
    vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,0, 4'd0));
    vecs.push_back(mk(1, 1,0,0,0, 0,0,0,0,0, 4'd0));
    vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,1, 4'd1));
    vecs.push_back(mk(1, 1,1,0,0, 0,0,0,0,0, 4'd1));
    vecs.push_back(mk(1, 0,1,0,0, 1,0,0,0,1, 4'd0));
    vecs.push_back(mk(1, 0,0,0,0, 1,0,0,0,0, 4'd0));

    // Reset held with enter/green high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hold", pack(0,0,0,0,4'd0));
    enter = 1'b0; green_LED = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(0,0,0,0);
      chk($sformatf("post_reset_idle[%0d]", i), pack(0,0,0,0,4'd0));
    end

    for (int v = 0; v < vecs.size(); v++) begin
      for (int r = 0; r < vecs[v].rep; r++) begin
        apply(vecs[v].en, vecs[v].gr, vecs[v].rd, vecs[v].tk);
`ifdef ALARM_BLINK_EN
        exp_alm = vecs[v].blk;
`else
        exp_alm = vecs[v].alm;
`endif
        chk($sformatf("vec[%0d].%0d", v, r),
            pack(vecs[v].unl, exp_alm, vecs[v].lk, vecs[v].clr, vecs[v].fc));
      end
    end

    // Reset while OPEN: outputs drop without waiting for a clock
    reset = 1'b0;
    #1;
    chk("rst_mid_open", pack(0,0,0,0,4'd0));
    @(negedge clk);
    reset = 1'b1;
    apply(0,0,0,0);
    chk("rst_release_open", pack(0,0,0,0,4'd0));

    // Three failures into lockout, three ticks, then reset mid-lockout
    for (int i = 0; i < 3; i++) begin
      apply(1,0,1,0);
      apply(0,0,0,0);
      if (i < 2) chk($sformatf("fail_seq[%0d]", i), pack(0,0,0,1,4'(i + 1)));
      else       chk("fail_seq_lock", pack(0,1,1,1,4'd3));
    end
    for (int t = 1; t <= 3; t++) begin
      apply(0,0,0,1);
      repeat (4) apply(0,0,0,0);
`ifdef ALARM_BLINK_EN
      exp_alm = (t % 2 == 0);
`else
      exp_alm = 1'b1;
`endif
      chk($sformatf("lock_tick[%0d]", t), pack(0,exp_alm,1,0,4'd3));
    end
    reset = 1'b0;
    #1;
    chk("rst_mid_lockout", pack(0,0,0,0,4'd0));
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(0,0,0,0);
      chk($sformatf("rst_release_lock[%0d]", i), pack(0,0,0,0,4'd0));
    end
    apply(1,1,0,0);
    apply(0,1,0,0);
    chk("unlock_after_reset", pack(1,0,0,1,4'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
